// File: rtl/fx_mac_pkg.sv
// Shared command/state encodings and datapath widths for the FX MAC controller.
package fx_mac_pkg;

  localparam int OPER_W  = 16;
  localparam int ACC_W   = 32;
  localparam int CACHE_W = 2 * OPER_W;

  typedef enum logic [1:0] {
    OP_ACCUM = 2'd0,
    OP_RESET = 2'd1,
    OP_LOAD  = 2'd2,
    OP_PEEK  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

endpackage

// File: rtl/fx_mac_ctrl_if.sv
// Command/result handshake bundle between a requester (master) and fx_mac_ctrl (slave).
interface fx_mac_ctrl_if;
  import fx_mac_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_sub;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_sub, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sub, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

// File: rtl/fx_mac_cache.sv
// Byte-writable 32-bit operand cache. FX_MAC_CACHE_AUTOINC_EN replaces the byte
// index with an internal wrapping write pointer cleared by ptr_clr.
module fx_mac_cache
  import fx_mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [7:0]         wr_data,
  input  logic               ptr_clr,
  output logic [CACHE_W-1:0] cache
);

  logic [CACHE_W-1:0] cache_q;
  logic [CACHE_W-1:0] cache_d;
  logic [1:0]         sel_s;

`ifdef FX_MAC_CACHE_AUTOINC_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] unused_idx_s;

  assign unused_idx_s = wr_idx;
  assign sel_s        = ptr_q;

  // Pointer advance; a clear takes priority over a simultaneous write.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_clr) begin
      ptr_d = 2'd0;
    end else if (wr_en) begin
      ptr_d = ptr_q + 2'd1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_clr_s;

  assign unused_clr_s = ptr_clr;
  assign sel_s        = wr_idx;
`endif

  // Byte merge into the cache word.
  always_comb begin
    cache_d = cache_q;
    if (wr_en) begin
      cache_d[{sel_s, 3'b000} +: 8] = wr_data;
    end else begin
      cache_d = cache_q;
    end
  end

  // Cache register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= '0;
    end else begin
      cache_q <= cache_d;
    end
  end

  assign cache = cache_q;

endmodule

// File: rtl/fx_mac_ctrl.sv
// Command sequencer for an external signed 16x16 MAC: snapshots the operand cache,
// strobes the MAC for one cycle and returns the accumulator (see fx_mac_cache for FX_MAC_CACHE_AUTOINC_EN).
module fx_mac_ctrl
  import fx_mac_pkg::*;
#(
  parameter int CACHE_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_wr_en,
  input  logic [1:0]        cache_wr_idx,
  input  logic [7:0]        cache_wr_data,
  fx_mac_ctrl_if.slave      bus,
  output logic [OPER_W-1:0] mac_a,
  output logic [OPER_W-1:0] mac_b,
  output logic              mac_mult_en,
  output logic              mac_reset_accum,
  output logic              mac_accumulate,
  output logic              mac_add_or_sub,
  input  logic [ACC_W-1:0]  mac_result
);

  if (CACHE_BYTES != 4) begin : g_bad_cache_bytes
    $error("fx_mac_ctrl: CACHE_BYTES must be 4");
  end

  state_e             state_q, state_d;
  cmd_op_e            op_q, op_d;
  cmd_op_e            cmd_op_s;
  logic [CACHE_W-1:0] cache_s;
  logic [CACHE_W-1:0] snap_q, snap_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               mult_en_q, mult_en_d;
  logic               accumulate_q, accumulate_d;
  logic               reset_accum_q, reset_accum_d;
  logic               add_sub_q, add_sub_d;
  logic               accept_s;
  logic               ptr_clr_s;

  assign cmd_op_s  = cmd_op_e'(bus.cmd_op);
  assign accept_s  = bus.cmd_valid && cmd_ready_q;
  assign ptr_clr_s = accept_s && (cmd_op_s == OP_RESET);

  fx_mac_cache u_cache (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cache_wr_en),
    .wr_idx  (cache_wr_idx),
    .wr_data (cache_wr_data),
    .ptr_clr (ptr_clr_s),
    .cache   (cache_s)
  );

  // Next state; MAC strobes are decided at acceptance so they are live exactly during ISSUE.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    snap_d        = snap_q;
    res_data_d    = res_data_q;
    res_valid_d   = res_valid_q;
    mult_en_d     = 1'b1;
    accumulate_d  = 1'b0;
    reset_accum_d = 1'b0;
    add_sub_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
          op_d    = cmd_op_s;
          snap_d  = cache_s;
          case (cmd_op_s)
            OP_ACCUM: begin
              accumulate_d = 1'b1;
              add_sub_d    = bus.cmd_sub;
            end
            OP_LOAD: begin
              mult_en_d    = 1'b0;
              accumulate_d = 1'b1;
            end
            OP_RESET: reset_accum_d = 1'b1;
            OP_PEEK:  mult_en_d     = 1'b1;
            default:  mult_en_d     = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_RESET) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        res_data_d  = mac_result;
        res_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // Controller registers; the MAC clear strobe leaves reset high to wipe the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ACCUM;
      snap_q        <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      mult_en_q     <= 1'b1;
      accumulate_q  <= 1'b0;
      reset_accum_q <= 1'b1;
      add_sub_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      snap_q        <= snap_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      mult_en_q     <= mult_en_d;
      accumulate_q  <= accumulate_d;
      reset_accum_q <= reset_accum_d;
      add_sub_q     <= add_sub_d;
    end
  end

  assign mac_a           = snap_q[OPER_W-1:0];
  assign mac_b           = snap_q[CACHE_W-1:OPER_W];
  assign mac_mult_en     = mult_en_q;
  assign mac_accumulate  = accumulate_q;
  assign mac_reset_accum = reset_accum_q;
  assign mac_add_or_sub  = add_sub_q;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_fx_mac_ctrl.sv
// Self-checking bench for fx_mac_ctrl with a behavioural MAC and a command-level reference model.
module tb_fx_mac_ctrl;
  import fx_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cache_wr_en = 1'b0;
  logic [1:0]  cache_wr_idx = 2'd0;
  logic [7:0]  cache_wr_data = 8'd0;
  logic [15:0] mac_a, mac_b;
  logic        mac_mult_en, mac_reset_accum, mac_accumulate, mac_add_or_sub;
  logic [31:0] mac_result;

  fx_mac_ctrl_if bus ();

  fx_mac_ctrl #(.CACHE_BYTES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cache_wr_en     (cache_wr_en),
    .cache_wr_idx    (cache_wr_idx),
    .cache_wr_data   (cache_wr_data),
    .bus             (bus),
    .mac_a           (mac_a),
    .mac_b           (mac_b),
    .mac_mult_en     (mac_mult_en),
    .mac_reset_accum (mac_reset_accum),
    .mac_accumulate  (mac_accumulate),
    .mac_add_or_sub  (mac_add_or_sub),
    .mac_result      (mac_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sprod(input logic [15:0] a, input logic [15:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return 32'(pa * pb);
  endfunction

  // External MAC: signed multiply-accumulate, load when the multiplier is bypassed.
  logic [31:0] mac_acc = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mac_reset_accum) mac_acc <= 32'h0;
    else if (mac_accumulate && !mac_mult_en) mac_acc <= {mac_b, mac_a};
    else if (mac_accumulate && mac_add_or_sub) mac_acc <= mac_acc - sprod(mac_a, mac_b);
    else if (mac_accumulate) mac_acc <= mac_acc + sprod(mac_a, mac_b);
  end
  assign mac_result = mac_acc;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] ref_acc = 32'h0;
  logic [7:0]  m_bytes [4];
  int          m_ptr = 0;

  function automatic logic [31:0] model_word();
    return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [1:0] idx, input logic [7:0] d);
    cache_wr_en = 1'b1;
    cache_wr_idx = idx;
    cache_wr_data = d;
    @(posedge clk); #1;
    cache_wr_en = 1'b0;
`ifdef FX_MAC_CACHE_AUTOINC_EN
    m_bytes[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 4;
`else
    m_bytes[idx] = d;
`endif
  endtask

  task automatic wr_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) wr_byte(2'(i), w[8*i +: 8]);
  endtask

  // Waits for cmd_ready, accepts the command, checks ISSUE strobes and updates the model.
  task automatic issue(input logic [1:0] op, input logic sub, input logic scribble, output int waited);
    logic [31:0] snap;
    logic [3:0]  exp_strb;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_sub = sub;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_wait", 32'(waited < 40), 32'd1);
    snap = model_word();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    case (op)
      2'd0:    exp_strb = {1'b1, 1'b1, 1'b0, sub};
      2'd1:    exp_strb = 4'b1010;
      2'd2:    exp_strb = 4'b0100;
      default: exp_strb = 4'b1000;
    endcase
    chk("issue_strobes", {mac_mult_en, mac_accumulate, mac_reset_accum, mac_add_or_sub}, exp_strb);
    chk("issue_ready_low", bus.cmd_ready, 1'b0);
    chk("issue_operands", {mac_b, mac_a}, snap);
    case (op)
      2'd0: ref_acc = sub ? ref_acc - sprod(snap[15:0], snap[31:16]) : ref_acc + sprod(snap[15:0], snap[31:16]);
      2'd1: begin ref_acc = 32'h0; m_ptr = 0; end
      2'd2: ref_acc = snap;
      default: ;
    endcase
    if (scribble) wr_byte(2'($urandom_range(0, 3)), 8'($urandom));
    else begin @(posedge clk); #1; end
    chk("post_issue_strobes", {mac_mult_en, mac_accumulate, mac_reset_accum, mac_add_or_sub}, 4'b1000);
    chk("snapshot_held", {mac_b, mac_a}, snap);
  endtask

  // Entered one cycle after acceptance; checks result timing, hold behaviour and handshake.
  task automatic collect(input logic [1:0] op, input int hold, input logic next_valid, output logic [31:0] data);
    data = 32'h0;
    chk("capture_no_valid", bus.res_valid, 1'b0);
    if (op == 2'd1) begin
      chk("reset_ready_back", bus.cmd_ready, 1'b1);
      @(posedge clk); #1;
      chk("reset_no_result", bus.res_valid, 1'b0);
    end else begin
      chk("capture_ready_low", bus.cmd_ready, 1'b0);
      @(posedge clk); #1;
      chk("res_valid_rise", bus.res_valid, 1'b1);
      chk("res_data", bus.res_data, ref_acc);
      data = bus.res_data;
      if (next_valid) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'd3;
        bus.cmd_sub = 1'b0;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", bus.res_valid, 1'b1);
        chk("hold_data", bus.res_data, ref_acc);
        chk("hold_ready_low", bus.cmd_ready, 1'b0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk("drop_valid", bus.res_valid, 1'b0);
      chk("ready_after_out", bus.cmd_ready, 1'b1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    logic [31:0] d;
    logic [31:0] exp_word;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_sub = 1'b0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 32'h0);
    chk("rst_operands", {mac_b, mac_a}, 32'h0);
    chk("rst_reset_accum", mac_reset_accum, 1'b1);
    chk("rst_idle_strobes", {mac_mult_en, mac_accumulate, mac_add_or_sub}, 3'b100);
    rst_n = 1'b1;
    chk("release_reset_accum_hi", mac_reset_accum, 1'b1);
    chk("release_ready_low", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("first_edge_reset_accum_lo", mac_reset_accum, 1'b0);
    chk("first_edge_ready", bus.cmd_ready, 1'b1);

    // Accumulator cleared by the reset strobe
    issue(2'd3, 1'b0, 1'b0, w);
    collect(2'd3, 0, 1'b0, d);
    chk("peek_after_reset", d, 32'h0);

    // RESET command: no result, ready again two edges after acceptance
    issue(2'd1, 1'b0, 1'b0, w);
    collect(2'd1, 0, 1'b0, d);

    // 3 * -2 accumulated, then subtracted back out
    wr_word(32'hFFFE_0003);
    issue(2'd0, 1'b0, 1'b0, w);
    collect(2'd0, 0, 1'b0, d);
    chk("accum_add", d, 32'hFFFF_FFFA);
    issue(2'd0, 1'b1, 1'b0, w);
    collect(2'd0, 0, 1'b0, d);
    chk("accum_sub", d, 32'h0000_0000);

    // LOAD bypasses the multiplier
    wr_word(32'h1234_5678);
    issue(2'd2, 1'b0, 1'b0, w);
    collect(2'd2, 0, 1'b0, d);
    chk("load", d, 32'h1234_5678);

    // Back-pressure with a queued command waiting for the handshake
    wr_word(32'h0002_0003);
    issue(2'd0, 1'b0, 1'b0, w);
    collect(2'd0, 5, 1'b1, d);
    issue(2'd3, 1'b0, 1'b0, w);
    chk("queued_accept_immediate", w, 32'd0);
    collect(2'd3, 0, 1'b0, d);
    chk("accum_after_backpressure", d, 32'h1234_567E);

    // Modulo 2^32 wrap
    wr_word(32'hFFFF_FFFF);
    issue(2'd2, 1'b0, 1'b0, w);
    collect(2'd2, 0, 1'b0, d);
    wr_word(32'h0001_0001);
    issue(2'd0, 1'b0, 1'b0, w);
    collect(2'd0, 1, 1'b0, d);
    chk("wrap", d, 32'h0000_0000);

    // Byte placement: pointer-driven or index-driven
    issue(2'd1, 1'b0, 1'b0, w);
    collect(2'd1, 0, 1'b0, d);
    wr_byte(2'd2, 8'h11);
    wr_byte(2'd0, 8'h22);
    wr_byte(2'd3, 8'h33);
    wr_byte(2'd1, 8'h44);
    wr_byte(2'd2, 8'h55);
`ifdef FX_MAC_CACHE_AUTOINC_EN
    exp_word = 32'h4433_2255;
`else
    exp_word = 32'h3355_4422;
`endif
    issue(2'd2, 1'b0, 1'b0, w);
    collect(2'd2, 0, 1'b0, d);
    chk("byte_placement", d, exp_word);
    issue(2'd1, 1'b0, 1'b0, w);
    collect(2'd1, 0, 1'b0, d);

    // Reset during CAPTURE drops the result and re-clears the MAC
    wr_word(32'h0001_0007);
    issue(2'd0, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", bus.res_valid, 1'b0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("midrst_reset_accum", mac_reset_accum, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_res_valid_held", bus.res_valid, 1'b0);
    rst_n = 1'b1;
    chk("midrst_release_reset_accum", mac_reset_accum, 1'b1);
    @(posedge clk); #1;
    chk("midrst_first_edge_reset_accum", mac_reset_accum, 1'b0);
    chk("midrst_first_edge_ready", bus.cmd_ready, 1'b1);
    chk("midrst_first_edge_valid", bus.res_valid, 1'b0);
    ref_acc = 32'h0;
    m_ptr = 0;
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    issue(2'd3, 1'b0, 1'b0, w);
    collect(2'd3, 0, 1'b0, d);
    chk("midrst_peek", d, 32'h0);

    // Randomized command stream against the reference model
    for (int it = 0; it < 40; it++) begin
      int         nw;
      logic [1:0] rop;
      logic       rsub;
      int         rhold;
      logic       rscr;
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) wr_byte(2'($urandom_range(0, 3)), 8'($urandom));
      rop = 2'($urandom_range(0, 3));
      rsub = 1'($urandom_range(0, 1));
      rhold = $urandom_range(0, 3);
      rscr = 1'($urandom_range(0, 1));
      issue(rop, rsub, rscr, w);
      collect(rop, rhold, 1'b0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
